// File: rtl/entry_sequencer_if.sv
// Bundle of signals between the entry sequencer, the board inputs and the datapath.
// The master side is the sequencer. The slave side is whatever drives enter/op_done and consumes the strobes.
interface entry_sequencer_if #(
  parameter int BYTES = 4,
  parameter int PAGES = 4
);
  localparam int SEL_W  = $clog2(2 * BYTES);
  localparam int PAGE_W = $clog2(PAGES);

  logic              enter;
  logic              op_done;
  logic              byte_we;
  logic [SEL_W-1:0]  byte_sel;
  logic              op_start;
  logic              operand_ready;
  logic [PAGE_W-1:0] disp_page;
  logic [2:0]        state;

  modport master (
    input  enter, op_done,
    output byte_we, byte_sel, op_start, operand_ready, disp_page, state
  );

  modport slave (
    output enter, op_done,
    input  byte_we, byte_sel, op_start, operand_ready, disp_page, state
  );
endinterface

// File: rtl/entry_sequencer.sv
// Sequences byte entry of two operands from a debounced enter button, starts the arithmetic unit,
// then pages the result display. All outputs are registered.
module entry_sequencer #(
  parameter int BYTES = 4,
  parameter int PAGES = 4
) (
  input  logic               clk,
  input  logic               nreset,
  entry_sequencer_if.master  bus
);
  localparam int SEL_W  = $clog2(2 * BYTES);
  localparam int PAGE_W = $clog2(PAGES);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] SHOW   = 3'd4;

  localparam logic [SEL_W-1:0]  LAST_A    = SEL_W'(BYTES - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(2 * BYTES - 1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES - 1);

  logic sync1_q, sync2_q, prev_q;
  logic enter_pulse;

  logic [2:0]        state_q, state_d;
  logic              byte_we_q, byte_we_d;
  logic [SEL_W-1:0]  byte_sel_q, byte_sel_d;
  logic              op_start_q, op_start_d;
  logic              operand_ready_q, operand_ready_d;
  logic [PAGE_W-1:0] disp_page_q, disp_page_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.enter;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign enter_pulse = sync2_q & ~prev_q;

  // A strobe cycle always follows a pulse, so the index advances on the cycle after byte_we.
  always_comb begin
    state_d     = state_q;
    byte_we_d   = 1'b0;
    byte_sel_d  = byte_sel_q;
    disp_page_d = disp_page_q;
    case (state_q)
      LOAD_A, LOAD_B: begin
        if (byte_we_q) begin
          if (byte_sel_q == LAST_SEL) begin
            state_d = START;
          end else begin
            byte_sel_d = byte_sel_q + SEL_W'(1);
            if (byte_sel_q == LAST_A) state_d = LOAD_B;
          end
        end else if (enter_pulse) begin
          byte_we_d = 1'b1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.op_done) begin
          state_d     = SHOW;
          disp_page_d = '0;
        end
      end
      SHOW: begin
        if (enter_pulse) begin
          if (disp_page_q == LAST_PAGE) begin
            state_d     = LOAD_A;
            byte_sel_d  = '0;
            disp_page_d = '0;
          end else begin
            disp_page_d = disp_page_q + PAGE_W'(1);
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
    op_start_d      = (state_d == START) && (state_q != START);
    operand_ready_d = (state_d == START) || (state_d == WAIT) || (state_d == SHOW);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q         <= LOAD_A;
      byte_we_q       <= 1'b0;
      byte_sel_q      <= '0;
      op_start_q      <= 1'b0;
      operand_ready_q <= 1'b0;
      disp_page_q     <= '0;
    end else begin
      state_q         <= state_d;
      byte_we_q       <= byte_we_d;
      byte_sel_q      <= byte_sel_d;
      op_start_q      <= op_start_d;
      operand_ready_q <= operand_ready_d;
      disp_page_q     <= disp_page_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.byte_we       = byte_we_q;
  assign bus.byte_sel      = byte_sel_q;
  assign bus.op_start      = op_start_q;
  assign bus.operand_ready = operand_ready_q;
  assign bus.disp_page     = disp_page_q;
endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer: a per-cycle vector table covering a full entry/compute/display
// round, plus hand-written held-button and asynchronous-reset sequences.
module tb_entry_sequencer;
  logic clk;
  logic nreset;

  entry_sequencer_if #(.BYTES(4), .PAGES(4)) bus ();

  entry_sequencer #(.BYTES(4), .PAGES(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       enter;
    logic       op_done;
    logic [2:0] exp_state;
    logic       exp_we;
    logic [2:0] exp_sel;
    logic       exp_start;
    logic       exp_ready;
    logic [1:0] exp_page;
  } vec_t;

  vec_t vec [32];
  int checks = 0;
  int errors = 0;

  // Inputs change on the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(input logic e, input logic d);
    @(negedge clk);
    bus.enter   = e;
    bus.op_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st, input logic we,
                             input logic [2:0] sel, input logic ost, input logic rdy,
                             input logic [1:0] pg);
    logic [10:0] got, want;
    got  = {bus.state, bus.byte_we, bus.byte_sel, bus.op_start, bus.operand_ready, bus.disp_page};
    want = {st, we, sel, ost, rdy, pg};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got st/we/sel/start/rdy/page=%b want %b", name, got, want);
    end
  endtask

  task automatic doReset();
    nreset      = 1'b0;
    bus.enter   = 1'b0;
    bus.op_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic runTable(input int pass);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vec[i].enter, vec[i].op_done);
      checkOutput($sformatf("table%0d row %0d", pass, i), vec[i].exp_state, vec[i].exp_we,
                  vec[i].exp_sel, vec[i].exp_start, vec[i].exp_ready, vec[i].exp_page);
    end
  endtask

  initial begin
    int we_count;
    int we_sel;

    // enter, op_done, state, byte_we, byte_sel, op_start, ready, page
    vec[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vec[2]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    vec[3]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    vec[4]  = '{1, 0, 0, 1, 1, 0, 0, 0};
    vec[5]  = '{0, 1, 0, 0, 2, 0, 0, 0};
    vec[6]  = '{1, 0, 0, 1, 2, 0, 0, 0};
    vec[7]  = '{0, 0, 0, 0, 3, 0, 0, 0};
    vec[8]  = '{1, 0, 0, 1, 3, 0, 0, 0};
    vec[9]  = '{0, 0, 1, 0, 4, 0, 0, 0};
    vec[10] = '{1, 0, 1, 1, 4, 0, 0, 0};
    vec[11] = '{0, 0, 1, 0, 5, 0, 0, 0};
    vec[12] = '{1, 0, 1, 1, 5, 0, 0, 0};
    vec[13] = '{0, 0, 1, 0, 6, 0, 0, 0};
    vec[14] = '{1, 0, 1, 1, 6, 0, 0, 0};
    vec[15] = '{0, 0, 1, 0, 7, 0, 0, 0};
    vec[16] = '{1, 1, 1, 1, 7, 0, 0, 0};
    vec[17] = '{0, 1, 2, 0, 7, 1, 1, 0};
    vec[18] = '{1, 0, 3, 0, 7, 0, 1, 0};
    vec[19] = '{0, 0, 3, 0, 7, 0, 1, 0};
    vec[20] = '{0, 0, 3, 0, 7, 0, 1, 0};
    vec[21] = '{0, 1, 4, 0, 7, 0, 1, 0};
    vec[22] = '{1, 0, 4, 0, 7, 0, 1, 0};
    vec[23] = '{0, 0, 4, 0, 7, 0, 1, 0};
    vec[24] = '{1, 0, 4, 0, 7, 0, 1, 1};
    vec[25] = '{0, 0, 4, 0, 7, 0, 1, 1};
    vec[26] = '{1, 0, 4, 0, 7, 0, 1, 2};
    vec[27] = '{0, 0, 4, 0, 7, 0, 1, 2};
    vec[28] = '{1, 0, 4, 0, 7, 0, 1, 3};
    vec[29] = '{0, 0, 4, 0, 7, 0, 1, 3};
    vec[30] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vec[31] = '{0, 0, 0, 0, 0, 0, 0, 0};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("idle cycle %0d", i), 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
    end

    runTable(0);

    // A button held for 20 cycles must give a single strobe at byte 0.
    we_count = 0;
    we_sel   = -1;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(i < 20, 1'b0);
      if (bus.byte_we === 1'b1) begin
        we_count++;
        we_sel = int'(bus.byte_sel);
      end
    end
    checks++;
    if (we_count != 1 || we_sel != 0) begin
      errors++;
      $display("[TB] FAIL held strobes got count=%0d sel=%0d want count=1 sel=0", we_count, we_sel);
    end
    checkOutput("held end", 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 2'd0);

    // Five strobes, then reset asserted between edges must clear outputs immediately.
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus((i % 2 == 0) && (i < 10), 1'b0);
    checkOutput("five strobes", 3'd1, 1'b0, 3'd5, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    checkOutput("async reset", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;

    runTable(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
